// File: rtl/shift_register_sipo_latched.sv
// Multi-lane serial-in/parallel-out capture register with a strobe-latched,
// double-buffered output, selectable bit order, bit counter and overflow tracking.
module shift_register_sipo_latched #(
   parameter  int DEPTH       = 8,
   parameter  int LANES       = 1,
   parameter  int MSB_FIRST   = 1,
   localparam int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [LANES-1:0]         write_data,
   input  logic                     write_enable,
   input  logic                     latch,
   input  logic                     clear,
   output logic [LANES*DEPTH-1:0]   read_data,
   output logic                     read_valid,
   output logic                     frame_overflow,
   output logic [COUNT_WIDTH-1:0]   bit_count,
   output logic                     overflow
);

   localparam logic [COUNT_WIDTH-1:0] DEPTH_C = COUNT_WIDTH'(DEPTH);
   localparam logic [COUNT_WIDTH-1:0] ONE_C   = COUNT_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0] ZERO_C  = COUNT_WIDTH'(0);

   logic [LANES*DEPTH-1:0] r_shift_buf;
   logic [LANES*DEPTH-1:0] r_read_data;
   logic [COUNT_WIDTH-1:0] r_bit_count;
   logic                   r_overflow;
   logic                   r_frame_overflow;
   logic                   r_read_valid;

   logic [LANES*DEPTH-1:0] w_shifted_buf;
   logic [LANES*DEPTH-1:0] w_buf_next;
   logic [COUNT_WIDTH-1:0] w_count_next;
   logic                   w_overflow_next;
   logic                   w_count_full;

   // Per-lane shift network; the bit order decides which end receives the new bit.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [DEPTH-1:0] w_lane;
      assign w_lane = r_shift_buf[l*DEPTH +: DEPTH];
      if (MSB_FIRST != 0) begin : g_msb
         assign w_shifted_buf[l*DEPTH +: DEPTH] = {w_lane[DEPTH-2:0], write_data[l]};
      end else begin : g_lsb
         assign w_shifted_buf[l*DEPTH +: DEPTH] = {write_data[l], w_lane[DEPTH-1:1]};
      end
   end

   assign w_count_full = (r_bit_count == DEPTH_C);

   // Frame state as it stands after this cycle's write, before latch/clear apply.
   always_comb begin
      w_buf_next      = r_shift_buf;
      w_count_next    = r_bit_count;
      w_overflow_next = r_overflow;
      if (write_enable) begin
         w_buf_next = w_shifted_buf;
         if (w_count_full) begin
            w_count_next    = r_bit_count;
            w_overflow_next = 1'b1;
         end else begin
            w_count_next    = r_bit_count + ONE_C;
            w_overflow_next = r_overflow;
         end
      end else begin
         w_buf_next      = r_shift_buf;
         w_count_next    = r_bit_count;
         w_overflow_next = r_overflow;
      end
   end

   // Capture side: shift buffer and live frame counters; clear beats write and latch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift_buf <= '0;
         r_bit_count <= ZERO_C;
         r_overflow  <= 1'b0;
      end else if (clear) begin
         r_shift_buf <= '0;
         r_bit_count <= ZERO_C;
         r_overflow  <= 1'b0;
      end else if (latch) begin
         r_shift_buf <= w_buf_next;
         r_bit_count <= ZERO_C;
         r_overflow  <= 1'b0;
      end else begin
         r_shift_buf <= w_buf_next;
         r_bit_count <= w_count_next;
         r_overflow  <= w_overflow_next;
      end
   end

   // Output side: the latched frame includes a write made in the latch cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_read_data      <= '0;
         r_frame_overflow <= 1'b0;
         r_read_valid     <= 1'b0;
      end else if (clear) begin
         r_read_data      <= r_read_data;
         r_frame_overflow <= r_frame_overflow;
         r_read_valid     <= 1'b0;
      end else if (latch) begin
         r_read_data      <= w_buf_next;
         r_frame_overflow <= w_overflow_next;
         r_read_valid     <= 1'b1;
      end else begin
         r_read_data      <= r_read_data;
         r_frame_overflow <= r_frame_overflow;
         r_read_valid     <= 1'b0;
      end
   end

   assign read_data      = r_read_data;
   assign read_valid     = r_read_valid;
   assign frame_overflow = r_frame_overflow;
   assign bit_count      = r_bit_count;
   assign overflow       = r_overflow;

endmodule

// File: tb/tb_shift_register_sipo_latched.sv
// Directed bench: a two-lane MSB-first instance and a one-lane LSB-first instance.
module tb_shift_register_sipo_latched;

   logic clk;
   logic rst_n;

   logic [1:0]  a_wd;
   logic        a_we, a_latch, a_clear;
   logic [15:0] a_rd;
   logic        a_rv, a_fo, a_ov;
   logic [3:0]  a_bc;

   logic        b_wd;
   logic        b_we, b_latch, b_clear;
   logic [7:0]  b_rd;
   logic        b_rv, b_fo, b_ov;
   logic [3:0]  b_bc;

   int cmp_cnt;
   int err_cnt;

   shift_register_sipo_latched #(.DEPTH(8), .LANES(2), .MSB_FIRST(1)) u_msb (
      .clk(clk), .reset(rst_n), .write_data(a_wd), .write_enable(a_we),
      .latch(a_latch), .clear(a_clear), .read_data(a_rd), .read_valid(a_rv),
      .frame_overflow(a_fo), .bit_count(a_bc), .overflow(a_ov)
   );

   shift_register_sipo_latched #(.DEPTH(8), .LANES(1), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .reset(rst_n), .write_data(b_wd), .write_enable(b_we),
      .latch(b_latch), .clear(b_clear), .read_data(b_rd), .read_valid(b_rv),
      .frame_overflow(b_fo), .bit_count(b_bc), .overflow(b_ov)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc_a(input logic we, input logic [1:0] wd, input logic lt, input logic cl);
      a_we = we; a_wd = wd; a_latch = lt; a_clear = cl;
      @(posedge clk); #1;
      a_we = 1'b0; a_wd = 2'b00; a_latch = 1'b0; a_clear = 1'b0;
   endtask

   task automatic cyc_b(input logic we, input logic wd, input logic lt, input logic cl);
      b_we = we; b_wd = wd; b_latch = lt; b_clear = cl;
      @(posedge clk); #1;
      b_we = 1'b0; b_wd = 1'b0; b_latch = 1'b0; b_clear = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      cmp_cnt++;
      if (a_rd !== 16'h0000 || a_rv !== 1'b0 || a_fo !== 1'b0 || a_bc !== 4'd0 || a_ov !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_a: got rd=%h rv=%b fo=%b bc=%0d ov=%b want all zero", a_rd, a_rv, a_fo, a_bc, a_ov);
      end
      cmp_cnt++;
      if (b_rd !== 8'h00 || b_rv !== 1'b0 || b_fo !== 1'b0 || b_bc !== 4'd0 || b_ov !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_b: got rd=%h rv=%b fo=%b bc=%0d ov=%b want all zero", b_rd, b_rv, b_fo, b_bc, b_ov);
      end
      repeat (2) @(posedge clk);
      #4 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_msb_two_lanes;
      logic [7:0] l0, l1;
      l0 = 8'hA5; l1 = 8'h3C;
      for (int i = 7; i >= 0; i--) cyc_a(1'b1, {l1[i], l0[i]}, 1'b0, 1'b0);
      cmp_cnt++;
      if (a_bc !== 4'd8 || a_ov !== 1'b0) begin
         err_cnt++;
         $display("FAIL msb_count: got bc=%0d ov=%b want bc=8 ov=0", a_bc, a_ov);
      end
      cyc_a(1'b0, 2'b00, 1'b1, 1'b0);
      cmp_cnt++;
      if (a_rd !== 16'h3CA5 || a_rv !== 1'b1 || a_fo !== 1'b0 || a_bc !== 4'd0) begin
         err_cnt++;
         $display("FAIL msb_latch: got rd=%h rv=%b fo=%b bc=%0d want rd=3ca5 rv=1 fo=0 bc=0", a_rd, a_rv, a_fo, a_bc);
      end
      cyc_a(1'b0, 2'b00, 1'b0, 1'b0);
      cmp_cnt++;
      if (a_rv !== 1'b0 || a_rd !== 16'h3CA5) begin
         err_cnt++;
         $display("FAIL msb_pulse: got rv=%b rd=%h want rv=0 rd=3ca5", a_rv, a_rd);
      end
   endtask

   task automatic test_lsb_one_lane;
      logic [7:0] v;
      v = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         cyc_b(1'b1, v[i], 1'b0, 1'b0);
         cmp_cnt++;
         if (b_bc !== 4'(i + 1)) begin
            err_cnt++;
            $display("FAIL lsb_count: got %0d want %0d", b_bc, i + 1);
         end
      end
      cyc_b(1'b0, 1'b0, 1'b1, 1'b0);
      cmp_cnt++;
      if (b_rd !== 8'hA5 || b_rv !== 1'b1 || b_fo !== 1'b0 || b_bc !== 4'd0) begin
         err_cnt++;
         $display("FAIL lsb_latch: got rd=%h rv=%b fo=%b bc=%0d want rd=a5 rv=1 fo=0 bc=0", b_rd, b_rv, b_fo, b_bc);
      end
   endtask

   task automatic test_overflow;
      logic [8:0] bits;
      bits = 9'b1_0000_0001;
      for (int i = 8; i >= 0; i--) cyc_a(1'b1, {1'b0, bits[i]}, 1'b0, 1'b0);
      cmp_cnt++;
      if (a_bc !== 4'd8 || a_ov !== 1'b1) begin
         err_cnt++;
         $display("FAIL ovf_count: got bc=%0d ov=%b want bc=8 ov=1", a_bc, a_ov);
      end
      cyc_a(1'b0, 2'b00, 1'b1, 1'b0);
      cmp_cnt++;
      if (a_rd !== 16'h0001 || a_fo !== 1'b1 || a_ov !== 1'b0 || a_rv !== 1'b1) begin
         err_cnt++;
         $display("FAIL ovf_latch: got rd=%h fo=%b ov=%b rv=%b want rd=0001 fo=1 ov=0 rv=1", a_rd, a_fo, a_ov, a_rv);
      end
      cyc_a(1'b0, 2'b00, 1'b1, 1'b0);
      cmp_cnt++;
      if (a_rd !== 16'h0001 || a_fo !== 1'b0 || a_rv !== 1'b1) begin
         err_cnt++;
         $display("FAIL ovf_relatch: got rd=%h fo=%b rv=%b want rd=0001 fo=0 rv=1", a_rd, a_fo, a_rv);
      end
   endtask

   task automatic test_write_with_latch;
      logic [7:0] l0, l1;
      l0 = 8'hA5; l1 = 8'h0F;
      for (int i = 7; i >= 1; i--) cyc_a(1'b1, {l1[i], l0[i]}, 1'b0, 1'b0);
      cmp_cnt++;
      if (a_bc !== 4'd7) begin
         err_cnt++;
         $display("FAIL wl_count: got %0d want 7", a_bc);
      end
      cyc_a(1'b1, {l1[0], l0[0]}, 1'b1, 1'b0);
      cmp_cnt++;
      if (a_rd !== 16'h0FA5 || a_bc !== 4'd0 || a_ov !== 1'b0 || a_fo !== 1'b0 || a_rv !== 1'b1) begin
         err_cnt++;
         $display("FAIL wl_latch: got rd=%h bc=%0d ov=%b fo=%b rv=%b want rd=0fa5 bc=0 ov=0 fo=0 rv=1", a_rd, a_bc, a_ov, a_fo, a_rv);
      end
   endtask

   task automatic test_clear_priority;
      logic [7:0] l0, l1;
      for (int i = 0; i < 4; i++) cyc_a(1'b1, 2'b01, 1'b0, 1'b0);
      cyc_a(1'b1, 2'b11, 1'b1, 1'b1);
      cmp_cnt++;
      if (a_rd !== 16'h0FA5 || a_rv !== 1'b0 || a_bc !== 4'd0 || a_ov !== 1'b0 || a_fo !== 1'b0) begin
         err_cnt++;
         $display("FAIL clr_prio: got rd=%h rv=%b bc=%0d ov=%b fo=%b want rd=0fa5 rv=0 bc=0 ov=0 fo=0", a_rd, a_rv, a_bc, a_ov, a_fo);
      end
      // Short frame after clear exposes whether the buffer was zeroed.
      for (int i = 0; i < 4; i++) cyc_a(1'b1, 2'b01, 1'b0, 1'b0);
      cyc_a(1'b0, 2'b00, 1'b1, 1'b0);
      cmp_cnt++;
      if (a_rd !== 16'h000F || a_fo !== 1'b0 || a_rv !== 1'b1) begin
         err_cnt++;
         $display("FAIL clr_short: got rd=%h fo=%b rv=%b want rd=000f fo=0 rv=1", a_rd, a_fo, a_rv);
      end
      l0 = 8'h5A; l1 = 8'hC3;
      for (int i = 7; i >= 0; i--) cyc_a(1'b1, {l1[i], l0[i]}, 1'b0, 1'b0);
      cyc_a(1'b0, 2'b00, 1'b1, 1'b0);
      cmp_cnt++;
      if (a_rd !== 16'hC35A || a_fo !== 1'b0 || a_rv !== 1'b1) begin
         err_cnt++;
         $display("FAIL clr_clean: got rd=%h fo=%b rv=%b want rd=c35a fo=0 rv=1", a_rd, a_fo, a_rv);
      end
   endtask

   task automatic test_reset_mid_frame;
      logic [7:0] v;
      for (int i = 0; i < 8; i++) cyc_b(1'b1, 1'b1, 1'b0, 1'b0);
      cyc_b(1'b0, 1'b0, 1'b1, 1'b0);
      cmp_cnt++;
      if (b_rd !== 8'hFF) begin
         err_cnt++;
         $display("FAIL rst_pre_latch: got %h want ff", b_rd);
      end
      for (int i = 0; i < 4; i++) cyc_b(1'b1, 1'b0, 1'b0, 1'b0);
      cmp_cnt++;
      if (b_bc !== 4'd4) begin
         err_cnt++;
         $display("FAIL rst_pre_count: got %0d want 4", b_bc);
      end
      #2 rst_n = 1'b0;
      #1;
      cmp_cnt++;
      if (b_rd !== 8'h00 || b_rv !== 1'b0 || b_fo !== 1'b0 || b_bc !== 4'd0 || b_ov !== 1'b0) begin
         err_cnt++;
         $display("FAIL rst_mid: got rd=%h rv=%b fo=%b bc=%0d ov=%b want all zero", b_rd, b_rv, b_fo, b_bc, b_ov);
      end
      cmp_cnt++;
      if (a_rd !== 16'h0000 || a_bc !== 4'd0) begin
         err_cnt++;
         $display("FAIL rst_mid_a: got rd=%h bc=%0d want 0000 0", a_rd, a_bc);
      end
      #2 rst_n = 1'b1;
      v = 8'h5A;
      for (int i = 0; i < 8; i++) cyc_b(1'b1, v[i], 1'b0, 1'b0);
      cyc_b(1'b0, 1'b0, 1'b1, 1'b0);
      cmp_cnt++;
      if (b_rd !== 8'h5A || b_rv !== 1'b1 || b_fo !== 1'b0) begin
         err_cnt++;
         $display("FAIL rst_after: got rd=%h rv=%b fo=%b want rd=5a rv=1 fo=0", b_rd, b_rv, b_fo);
      end
   endtask

   initial begin
      cmp_cnt = 0; err_cnt = 0;
      a_wd = 2'b00; a_we = 1'b0; a_latch = 1'b0; a_clear = 1'b0;
      b_wd = 1'b0;  b_we = 1'b0; b_latch = 1'b0; b_clear = 1'b0;
      test_reset();
      test_msb_two_lanes();
      test_lsb_one_lane();
      test_overflow();
      test_write_with_latch();
      test_clear_priority();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/shift_register_sipo_latched.md
# shift_register_sipo_latched

Multi-lane serial-in/parallel-out capture register with a double-buffered, strobe-latched output. It has the same structure as a printhead data path: DEPTH bits per lane are shifted in, and a latch strobe transfers the frame to the parallel outputs. It adds selectable bit order, a bit counter, a one-cycle valid pulse and a per-frame overflow flag. It sits between the mechanism's serial data/clock/latch decoders and the analyser's frame-checking logic.

## Interface
Parameters:
- DEPTH, 8, bits per lane per frame; must be ≥ 2.
- LANES, 1, number of parallel serial data lanes; must be ≥ 1.
- MSB_FIRST, 1, bit order: 1 means the first bit shifted ends in bit DEPTH-1; 0 means it ends in bit 0.
- COUNT_WIDTH (localparam), $clog2(DEPTH+1).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous active-low reset.
- write_data  in  LANES  serial bit per lane; lane l feeds frame l.
- write_enable  in  1  shift write_data into all lanes this cycle.
- latch  in  1  transfer the shift buffer to read_data.
- clear  in  1  synchronous discard of the frame in progress.
- read_data  out  LANES*DEPTH  latched frame; lane l at [l*DEPTH +: DEPTH].
- read_valid  out  1  one-cycle pulse when read_data has been updated.
- frame_overflow  out  1  overflow status of the frame held in read_data.
- bit_count  out  COUNT_WIDTH  bits shifted since the last latch/clear; saturates at DEPTH.
- overflow  out  1  sticky flag: more than DEPTH bits were shifted in the current frame.

## Operation
- Internal state: shift buffer (LANES*DEPTH), bit counter, live overflow flag, read_data register, frame_overflow register, read_valid register.
- Shift, applied per lane when write_enable=1:
  - MSB_FIRST=1: next = {buf[DEPTH-2:0], bit}.
  - MSB_FIRST=0: next = {bit, buf[DEPTH-1:1]}.
- Bit counter:
  - Increments on write_enable while bit_count < DEPTH.
  - A write at bit_count == DEPTH still shifts (the oldest bit is lost), holds the count at DEPTH and sets overflow.
- Latch (latch=1, clear=0):
  - read_data ← shift buffer after this cycle's shift, so a write in the same cycle is included.
  - frame_overflow ← overflow after this cycle's update.
  - read_valid pulses 1.
  - bit_count ← 0 and overflow ← 0.
  - The shift buffer is not cleared.
- Clear (clear=1):
  - Shift buffer ← 0, bit_count ← 0, overflow ← 0.
  - Priority over write_enable and latch: any shift that cycle is discarded, latch is ignored, read_data and frame_overflow hold, and read_valid stays 0.
- Latching a short frame (bit_count < DEPTH) is legal. It latches the buffer as-is with frame_overflow=0. Unshifted positions hold stale or zero bits.
- Reset (asynchronous, any time including mid-frame): shift buffer, read_data, read_valid, frame_overflow, bit_count and overflow all go to 0 immediately, with no clock edge needed. The first posedge after release operates normally.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latch latency:
  - latch sampled at edge N → read_data, frame_overflow and read_valid=1 visible after edge N.
  - read_valid returns to 0 after edge N+1 unless latch is sampled again.
- bit_count and overflow reflect the writes sampled up to and including the last edge.
- Back-to-back latches produce back-to-back read_valid pulses. A second latch with no writes in between re-latches the same data with frame_overflow=0.
- There is no handshake or back-pressure: write_enable may be asserted every cycle.

## Test plan
- DEPTH=8, LANES=2, MSB_FIRST=1: shift lane0 0xA5 and lane1 0x3C MSB first (8 writes), then latch → read_data=0x3CA5, read_valid high for exactly 1 cycle, frame_overflow=0, bit_count=0.
- MSB_FIRST=0, LANES=1: shift 0xA5 LSB first, then latch → read_data=0xA5. Verify bit_count steps 1..8 during the writes.
- Overflow (MSB_FIRST=1, LANES=1): 9 writes of bits 1,0,0,0,0,0,0,0,1 → bit_count=8, overflow=1. Then latch → read_data=0x01, frame_overflow=1, overflow=0. Latch again → frame_overflow=0.
- Simultaneous write and latch: 7 writes of 0xA5's first 7 bits, then the 8th write together with latch → read_data=0xA5, bit_count=0, overflow=0.
- Clear priority: 4 writes, then clear+latch+write_enable together → read_data unchanged from the previous frame, read_valid=0, bit_count=0. Next 8 writes + latch give a clean frame.
- Reset mid-frame: after 4 writes and one prior latch of 0xFF, drive reset low between edges → all outputs read 0 immediately. After release, normal capture of 0x5A succeeds.
